// File: rtl/data_register_pkg.sv
// data_register_pkg: shared word width, word type and reset value for data_register
package data_register_pkg;
   localparam int DATA_W = 24;
   typedef logic [DATA_W-1:0] data_word_t;
   localparam data_word_t DATA_RESET = '0;
endpackage

// File: rtl/data_register_parity.sv
// data_register_parity: even parity (XOR-reduce) of a WIDTH-bit word
module data_register_parity
   import data_register_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);
   assign parity = ^data;
endmodule

// File: rtl/data_register.sv
// data_register: enabled holding register with sync clear and load pulse;
// DATA_REGISTER_PARITY_EN adds a stored even-parity bit and a registered parity error flag
module data_register
   import data_register_pkg::*;
#(
   parameter int               WIDTH       = DATA_W,
   parameter logic [WIDTH-1:0] RESET_VALUE = DATA_RESET
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
`ifdef DATA_REGISTER_PARITY_EN
   output logic             parity_out,
   output logic             parity_err,
`endif
   output logic             loaded
);
   logic [WIDTH-1:0] r_data;
   logic             r_loaded;
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_data   <= RESET_VALUE;
         r_loaded <= 1'b0;
      end else begin
         if (enable) r_data <= data_in;
         r_loaded <= enable;
      end
   end
   assign data_out = r_data;
   assign loaded   = r_loaded;
`ifdef DATA_REGISTER_PARITY_EN
   localparam logic RESET_PAR = ^RESET_VALUE;
   logic w_gen_par;
   logic w_chk_par;
   logic r_par;
   logic r_perr;
   data_register_parity #(.WIDTH(WIDTH)) u_gen (.data(data_in), .parity(w_gen_par));
   data_register_parity #(.WIDTH(WIDTH)) u_chk (.data(r_data),  .parity(w_chk_par));
   // the error flag compares the word already stored against its stored parity
   always_ff @(posedge clk) begin
      r_par  <= (rst || clear) ? RESET_PAR : enable ? w_gen_par : r_par;
      r_perr <= (rst || clear) ? 1'b0 : (w_chk_par != r_par);
   end
   assign parity_out = r_par;
   assign parity_err = r_perr;
`endif
endmodule

// File: tb/tb_data_register.sv
// tb_data_register: directed self-checking bench for data_register (parity checks with DATA_REGISTER_PARITY_EN)
module tb_data_register;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [23:0] data_in = '0;
   logic [23:0] data_out;
   logic        loaded;
`ifdef DATA_REGISTER_PARITY_EN
   logic        parity_out;
   logic        parity_err;
`endif
   int total = 0;
   int bad = 0;

   data_register dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .data_in(data_in), .data_out(data_out),
`ifdef DATA_REGISTER_PARITY_EN
      .parity_out(parity_out), .parity_err(parity_err),
`endif
      .loaded(loaded)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; data_in = 24'hABCDEF;
      tick(); tick();
      total++; if (data_out !== 24'h000000) begin bad++; $display("FAIL reset_data got=%h exp=000000", data_out); end
      total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%b exp=0", loaded); end
`ifdef DATA_REGISTER_PARITY_EN
      total++; if (parity_out !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b exp=0", parity_out); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
`endif
      rst = 1'b0; enable = 1'b0;
   endtask

   task automatic test_load_hold();
      enable = 1'b1; data_in = 24'h123456;
      tick();
      total++; if (data_out !== 24'h123456) begin bad++; $display("FAIL load_data got=%h exp=123456", data_out); end
      total++; if (loaded !== 1'b1) begin bad++; $display("FAIL load_pulse got=%b exp=1", loaded); end
      enable = 1'b0; data_in = 24'hFFFFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (data_out !== 24'h123456) begin bad++; $display("FAIL hold_data[%0d] got=%h exp=123456", i, data_out); end
         total++; if (loaded !== 1'b0) begin bad++; $display("FAIL hold_loaded[%0d] got=%b exp=0", i, loaded); end
      end
      enable = 1'b1; data_in = 24'h123456;
      tick();
      total++; if (loaded !== 1'b1) begin bad++; $display("FAIL reload_pulse got=%b exp=1", loaded); end
      total++; if (data_out !== 24'h123456) begin bad++; $display("FAIL reload_data got=%h exp=123456", data_out); end
      enable = 1'b0;
   endtask

   task automatic test_clear();
      enable = 1'b1; clear = 1'b1; data_in = 24'h00F00D;
      tick();
      total++; if (data_out !== 24'h000000) begin bad++; $display("FAIL clear_data got=%h exp=000000", data_out); end
      total++; if (loaded !== 1'b0) begin bad++; $display("FAIL clear_loaded got=%b exp=0", loaded); end
      enable = 1'b0; clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [23:0] vec [3] = '{24'h000001, 24'h800000, 24'hFFFFFF};
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = vec[i];
         tick();
         total++; if (data_out !== vec[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, data_out, vec[i]); end
         total++; if (loaded !== 1'b1) begin bad++; $display("FAIL b2b_loaded[%0d] got=%b exp=1", i, loaded); end
      end
      enable = 1'b0; data_in = 24'h0000AA;
      tick();
      total++; if (loaded !== 1'b0) begin bad++; $display("FAIL b2b_end_loaded got=%b exp=0", loaded); end
      total++; if (data_out !== 24'hFFFFFF) begin bad++; $display("FAIL b2b_end_data got=%h exp=ffffff", data_out); end
   endtask

   task automatic test_rst_during_load();
      enable = 1'b1; data_in = 24'h7FFFFF;
      tick();
      total++; if (data_out !== 24'h7FFFFF) begin bad++; $display("FAIL pre_rst_data got=%h exp=7fffff", data_out); end
      rst = 1'b1; data_in = 24'h5A5A5A;
      tick();
      total++; if (data_out !== 24'h000000) begin bad++; $display("FAIL rst_load_data got=%h exp=000000", data_out); end
      total++; if (loaded !== 1'b0) begin bad++; $display("FAIL rst_load_loaded got=%b exp=0", loaded); end
      rst = 1'b0; enable = 1'b0;
   endtask

`ifdef DATA_REGISTER_PARITY_EN
   task automatic test_parity();
      enable = 1'b1; data_in = 24'h000007;
      tick();
      enable = 1'b0;
      total++; if (parity_out !== 1'b1) begin bad++; $display("FAIL par_out got=%b exp=1", parity_out); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_clean got=%b exp=0", parity_err); end
      tick();
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_hold got=%b exp=0", parity_err); end
      force dut.r_data = 24'h000006;
      tick();
      total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_flip got=%b exp=1", parity_err); end
      release dut.r_data;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_clear got=%b exp=0", parity_err); end
      total++; if (parity_out !== 1'b0) begin bad++; $display("FAIL par_out_clear got=%b exp=0", parity_out); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_hold();
      test_clear();
      test_back_to_back();
      test_rst_during_load();
`ifdef DATA_REGISTER_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
